// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit and its consumers:
// FSM encoding, reset address, buffer entry layout and decode field positions.
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction buffer geometry; only a 2-entry buffer is supported.
  localparam int FB_DEPTH = 2;
  localparam int CNT_W    = 2;
  localparam int PTR_W    = 1;

  // Field positions the decoder slices out of the fetched word.
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no request outstanding
    ST_FETCH = 2'd1,  // request raised, data will be kept
    ST_DRAIN = 2'd2   // request outstanding, data will be discarded
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, inst} entries between fetch and decode.
// Supports push, pop and a single-cycle flush; head entry is always visible.
module fetch_buffer
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  input  logic               flush,
  output logic               head_valid,
  output fetch_entry_t       head_entry,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is reset too, because the head entry drives inst/inst_pc, which must read zero out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_valid = (count_q != '0);
  assign head_entry = mem_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: single-outstanding memory request FSM feeding a
// 2-entry instruction buffer, with redirect flush and in-flight data discard.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = FB_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;      // next address to request
  logic [31:0]      addr_q, addr_d;  // address currently presented to memory
  logic [31:0]      target;
  logic             push, pop, has_space;
  logic [CNT_W-1:0] count, count_after;
  fetch_entry_t     push_entry, head_entry;

  assign imem_req   = (state_q != ST_IDLE);
  assign imem_addr  = addr_q;
  assign target     = word_align(redirect_pc);

  // A redirect kills both the word arriving this cycle and any pop by decode.
  assign push       = imem_req && imem_ack && (state_q == ST_FETCH) && !redirect;
  assign pop        = inst_valid && inst_ready && !redirect;
  assign push_entry = '{pc: addr_q, inst: imem_rdata};

  always_comb begin
    count_after = '0;
    if (!redirect) begin
      count_after = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Room for another request once this cycle's push/pop have landed.
  assign has_space = (count_after < CNT_W'(DEPTH));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          pc_d    = target;
          addr_d  = target;
          state_d = ST_FETCH;
        end else if (has_space) begin
          addr_d  = pc_q;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (redirect) begin
          pc_d = target;
          if (imem_ack) begin
            addr_d = target;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (imem_ack) begin
          pc_d   = addr_q + 32'd4;
          addr_d = addr_q + 32'd4;
          if (!has_space) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (redirect) begin
          pc_d = target;
        end
        if (imem_ack) begin
          addr_d  = redirect ? target : pc_q;
          state_d = has_space ? ST_FETCH : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= word_align(RESET_PC);
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .head_valid (inst_valid),
    .head_entry (head_entry),
    .count      (count)
  );

  assign inst    = head_entry.inst;
  assign inst_pc = head_entry.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a scoreboard queue of expected deliveries,
// a negedge monitor for decode pops and memory handshake stability.
module tb_inst_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b1;
  logic        ack_en = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory: acks whenever enabled, data is a fixed function of the address.
  assign imem_ack   = ack_en;
  assign imem_rdata = mem_word(imem_addr);

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_pcs(input logic [31:0] pcs[]);
    foreach (pcs[i]) exp_q.push_back(pcs[i]);
  endtask

  // Scoreboard monitor: a pop happens at the next edge when valid & ready and no redirect.
  always @(negedge clock) begin
    logic [31:0] e;
    if (!reset && inst_valid && inst_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got pc %h expected no delivery at %0t", inst_pc, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", inst_pc, e);
        check("sb_inst", inst, mem_word(e));
      end
    end
  end

  // Handshake monitor: an unacked request must hold req and address.
  logic        hs_pending = 1'b0;
  logic [31:0] hs_addr = 32'h0;
  always @(negedge clock) begin
    if (hs_pending) begin
      check("hs_req_hold", 32'(imem_req), 32'd1);
      check("hs_addr_hold", imem_addr, hs_addr);
    end
    hs_pending = !reset && imem_req && !imem_ack;
    hs_addr    = imem_addr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick(3);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);

    // Back-to-back streaming after reset release
    expect_pcs('{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18});
    reset = 1'b0;
    tick();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    check("first_valid_early", 32'(inst_valid), 32'd0);
    tick();
    check("first_valid", 32'(inst_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("stream_pc", inst_pc, 32'(i * 4));
      if (i < 3) tick();
    end

    // Decode stall: buffer fills to two and requests stop
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_pc", inst_pc, 32'hC);
      check("stall_inst", inst, mem_word(32'hC));
    end
    inst_ready = 1'b1;
    tick(3);
    ack_en = 1'b0;
    tick(2);
    check("quiet_req", 32'(imem_req), 32'd1);
    check("quiet_addr", imem_addr, 32'h1C);
    check("quiet_valid", 32'(inst_valid), 32'd0);

    // Redirect with request outstanding, ack three cycles later
    expect_pcs('{32'h100});
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    check("drain_addr", imem_addr, 32'h1C);
    check("drain_valid", 32'(inst_valid), 32'd0);
    tick();
    check("drain_addr2", imem_addr, 32'h1C);
    tick();
    check("drain_addr3", imem_addr, 32'h1C);
    ack_en = 1'b1;
    tick();
    check("redir_addr", imem_addr, 32'h100);
    check("redir_dropped", 32'(inst_valid), 32'd0);
    tick();
    check("redir_first_pc", inst_pc, 32'h100);
    tick();

    // Redirect coincident with ack and a pop
    expect_pcs('{32'h200});
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    check("coinc_valid", 32'(inst_valid), 32'd0);
    check("coinc_req", 32'(imem_req), 32'd1);
    check("coinc_addr", imem_addr, 32'h200);
    tick();
    check("coinc_pc", inst_pc, 32'h200);
    tick();

    // Address wrap at the top of memory
    expect_pcs('{32'hFFFF_FFFC, 32'h0});
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_valid", 32'(inst_valid), 32'd0);
    tick();
    check("wrap_pc_top", inst_pc, 32'hFFFF_FFFC);
    check("wrap_addr_zero", imem_addr, 32'h0);
    tick();
    check("wrap_pc_zero", inst_pc, 32'h0);
    ack_en = 1'b0;
    tick();
    check("pre_rst_req", 32'(imem_req), 32'd1);
    check("pre_rst_addr", imem_addr, 32'h4);

    // Reset mid-request, late ack ignored
    reset = 1'b1;
    tick();
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_valid", 32'(inst_valid), 32'd0);
    check("midrst_addr", imem_addr, 32'h0);
    reset = 1'b0;
    ack_en = 1'b1;
    expect_pcs('{32'h0});
    tick();
    check("postrst_req", 32'(imem_req), 32'd1);
    check("postrst_addr", imem_addr, 32'h0);
    check("postrst_valid", 32'(inst_valid), 32'd0);
    tick();
    check("postrst_pc", inst_pc, 32'h0);
    tick();

    // Redirect while idle, then repeated redirects during drain
    inst_ready = 1'b0;
    tick();
    check("full_idle_req", 32'(imem_req), 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0300;
    ack_en = 1'b0;
    tick();
    redirect = 1'b0;
    inst_ready = 1'b1;
    check("idle_redir_req", 32'(imem_req), 32'd1);
    check("idle_redir_addr", imem_addr, 32'h300);
    check("idle_redir_valid", 32'(inst_valid), 32'd0);
    tick();
    expect_pcs('{32'h500, 32'h504});
    redirect = 1'b1;
    redirect_pc = 32'h0000_0400;
    tick();
    redirect_pc = 32'h0000_0500;
    tick();
    redirect = 1'b0;
    ack_en = 1'b1;
    check("dbl_drain_addr", imem_addr, 32'h300);
    tick();
    check("dbl_latest_addr", imem_addr, 32'h500);
    check("dbl_dropped", 32'(inst_valid), 32'd0);
    tick();
    check("dbl_pc", inst_pc, 32'h500);
    tick();
    ack_en = 1'b0;
    tick(3);
    check("end_valid", 32'(inst_valid), 32'd0);
    check("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, instruction buffer entries; only 2 is supported.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 imem_req  out  1  instruction memory read request.
REQ-006 imem_addr  out  32  word-aligned read address; bits [1:0] always 0.
REQ-007 imem_ack  in  1  request accepted and imem_rdata valid in the same cycle.
REQ-008 imem_rdata  in  32  fetched instruction word.
REQ-009 redirect  in  1  resolved branch/jump from execute; flush and refetch.
REQ-010 redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0).
REQ-011 inst_valid  out  1  head buffer entry valid toward decode.
REQ-012 inst  out  32  head instruction; decode slices op=[31:26] and fn=[5:0].
REQ-013 inst_pc  out  32  address of inst.
REQ-014 inst_ready  in  1  decode accepts head entry when high with inst_valid.

Function
REQ-015 Memory handshake: imem_req, once raised, and imem_addr SHALL stay constant until the cycle imem_ack=1; imem_ack in the first cycle of req is legal; imem_ack while imem_req=0 is ignored.
REQ-016 At most one memory request SHALL be outstanding.
REQ-017 A new request SHALL be raised only when buffered count + outstanding < DEPTH, after accounting for a pop in the same cycle.
REQ-018 Back-to-back: with imem_ack every cycle and inst_ready=1, one instruction per cycle SHALL be delivered.
REQ-019 Fetch pc SHALL advance by 4 on each accepted (acked, non-discarded) request; 32'hFFFF_FFFC+4 wraps to 0.
REQ-020 Latency: imem_ack in cycle k SHALL produce inst_valid=1 with that word in cycle k+1 when the buffer was empty.
REQ-021 Pop on inst_valid & inst_ready; entries SHALL be delivered in fetch order; inst/inst_pc stable while inst_valid=1 and inst_ready=0.
REQ-022 Simultaneous push and pop at count=2 SHALL not be possible (REQ-017); at count=1 the count stays 1.
REQ-023 FSM states: IDLE (no request), FETCH (request raised), DRAIN (request outstanding, its data to be discarded).
REQ-024 IDLE->FETCH when REQ-017 allows; FETCH->IDLE on ack when no further space; FETCH->FETCH on ack with space.
REQ-025 redirect SHALL: flush the buffer (inst_valid=0 next cycle), load fetch pc with {redirect_pc[31:2],2'b00}, and ignore any pop in that cycle.
REQ-026 redirect in FETCH without imem_ack: go to DRAIN, keep old imem_addr/req until ack, discard that data, then request redirect_pc.
REQ-027 redirect in the same cycle as imem_ack: acked data SHALL be discarded; next request uses redirect_pc with no DRAIN.
REQ-028 redirect while in DRAIN: latest redirect_pc wins; stay in DRAIN.
REQ-029 redirect in IDLE: request to redirect_pc raised next cycle.

Reset
REQ-030 Reset SHALL force state IDLE, fetch pc=RESET_PC, count=0, imem_req=0, imem_addr=0, inst_valid=0, inst=0, inst_pc=0.
REQ-031 Reset mid-request SHALL abandon it; imem_req=0 the cycle after reset asserts; a late imem_ack is ignored.
REQ-032 First request (imem_addr=RESET_PC) SHALL be raised in the first cycle after reset deasserts.

Structure
REQ-033 Shared package holds the FSM state encoding, RESET_PC default and the instruction field bit positions shared with the decoder.
REQ-034 Buffer SHALL be a sub-module fetch_buffer (DEPTH-entry FIFO of {pc,inst}, push/pop/flush, count).

Verification
REQ-035 Reset release, imem_ack every cycle, inst_ready=1 -> inst_pc 0,4,8,12 on consecutive cycles, first inst_valid 2 cycles after reset low.
REQ-036 inst_ready=0 for 5 cycles -> exactly 2 entries buffered, imem_req low, inst stable; release -> order preserved, no loss or duplicate.
REQ-037 redirect to 32'h0000_0103 with request outstanding, ack 3 cycles later -> that data dropped, next imem_addr=32'h0000_0100, first delivered inst_pc=32'h0000_0100.
REQ-038 redirect coincident with imem_ack and a pop -> acked word and buffer discarded, next imem_addr=redirect target.
REQ-039 redirect_pc=32'hFFFF_FFFC, continuous ack -> inst_pc FFFF_FFFC then 0000_0000.
REQ-040 reset asserted while imem_req=1 and no ack -> imem_req=0 next cycle, inst_valid=0, post-reset first imem_addr=RESET_PC.
